// File: rtl/oifs_pkg.sv
// rtl/oifs_pkg.sv - shared OIFS link types and constants
//
// Purpose: types and constants used by both the transmit-side serializer and
// the receive-side deserializer of the OIFS link.
// Contents:
//   rx_state_e      - receive FSM states
//   OIFS_DATA_BITS  - payload bits per frame
//   OIFS_IDLE_LEVEL - line level while idle (and the stop-bit level)
package oifs_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_e;

  localparam int   OIFS_DATA_BITS  = 8;
  localparam logic OIFS_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/oifs_sync2.sv
// rtl/oifs_sync2.sv - two-flop synchronizer for one asynchronous input
//
// Purpose: brings an asynchronous single-bit input into the i_clk domain.
// The output lags the input by two clock cycles.
// Ports:
//   i_clk - destination clock
//   i_rst - synchronous, active-high reset; both flops load RESET_VAL
//   i_d   - asynchronous input
//   o_q   - synchronized output
module oifs_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/oifs_rx_uart.sv
// rtl/oifs_rx_uart.sv - OIFS receive-side 8N1 deserializer
//
// Purpose: oversamples the asynchronous line input, recovers 8N1 frames
// (idle high, LSB first) and reports each byte with a one-cycle strobe, or a
// framing-error strobe when the stop bit is low.
// Ports:
//   i_clk       - system clock
//   i_rst       - synchronous, active-high reset
//   i_locked    - PLL lock; while low the receiver is held in idle
//   i_rx        - raw asynchronous line input, idle level 1
//   o_data      - last correctly framed byte, held until the next good frame
//   o_valid     - one-cycle strobe, o_data is new this cycle
//   o_frame_err - one-cycle strobe, stop bit sampled low
//   o_busy      - high whenever the receiver is not idle
import oifs_pkg::*;

module oifs_rx_uart #(
  parameter int CLKS_PER_BIT = 99
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_locked,
  input  logic                      i_rx,
  output logic [OIFS_DATA_BITS-1:0] o_data,
  output logic                      o_valid,
  output logic                      o_frame_err,
  output logic                      o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  // The counter runs down to zero, so loads are one less than the interval.
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(OIFS_DATA_BITS - 1);

  logic s;

  rx_state_e                 state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [OIFS_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [OIFS_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      expired;

  oifs_sync2 #(
    .RESET_VAL (OIFS_IDLE_LEVEL)
  ) u_rx_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (s)
  );

  assign expired = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    // Lock loss wins over everything, including a stop-bit strobe.
    if (!i_locked) begin
      state_d = RX_IDLE;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (!s) begin
            cnt_d   = HALF_LOAD;
            state_d = RX_START;
          end
        end

        RX_START: begin
          if (expired) begin
            if (s) begin
              state_d = RX_IDLE;
            end else begin
              cnt_d   = BIT_LOAD;
              idx_d   = 3'd0;
              state_d = RX_DATA;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end

        RX_DATA: begin
          if (expired) begin
            shreg_d[idx_q] = s;
            cnt_d          = BIT_LOAD;
            if (idx_q == LAST_IDX) begin
              state_d = RX_STOP;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end

        RX_STOP: begin
          if (expired) begin
            if (s) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
              state_d = RX_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = RX_WAIT_HIGH;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end

        // A held-low line (break) must not look like a fresh start bit.
        RX_WAIT_HIGH: begin
          if (s) begin
            state_d = RX_IDLE;
          end
        end

        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Only ever read after all data bits of a frame were written.
  always_ff @(posedge i_clk) begin
    shreg_q <= shreg_d;
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_oifs_rx_uart.sv
// tb/tb_oifs_rx_uart.sv - directed self-checking bench for oifs_rx_uart
module tb_oifs_rx_uart;

  localparam int C = 99;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_locked = 1'b0;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  int nvalid = 0, nferr = 0, nboth = 0;
  int valid_cyc = 0, prev_valid_cyc = 0, ferr_cyc = 0;
  int busy_rise = 0, busy_fall = 0;
  logic [7:0] last_data = 8'h00, prev_data = 8'h00;
  logic busy_q = 1'b0;

  int fall, n0, f0;

  oifs_rx_uart #(.CLKS_PER_BIT(C)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_locked    (i_locked),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_valid) begin
      nvalid++;
      prev_valid_cyc = valid_cyc;
      valid_cyc = cyc;
      prev_data = last_data;
      last_data = o_data;
    end
    if (o_frame_err) begin
      nferr++;
      ferr_cyc = cyc;
    end
    if (o_valid && o_frame_err) nboth++;
    if (o_busy && !busy_q) busy_rise = cyc;
    if (!o_busy && busy_q) busy_fall = cyc;
    busy_q = o_busy;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    i_rx = v;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
    fall = cyc;
    drive(1'b0, C);
    for (int i = 0; i < 8; i++) drive(d[i], C);
    drive(stop, stop_len);
    i_rx = 1'b1;
  endtask

  initial begin
    repeat (5) @(negedge i_clk);
    check("rst_data", 32'(o_data), 32'h00);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_ferr", 32'(o_frame_err), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    i_rst = 1'b0;
    i_locked = 1'b1;
    repeat (10) @(negedge i_clk);

    // good frame 0xA5
    n0 = nvalid; f0 = nferr;
    send_frame(8'hA5, 1'b1, C);
    repeat (20) @(negedge i_clk);
    check("a5_count", 32'(nvalid - n0), 32'd1);
    check("a5_data", 32'(last_data), 32'hA5);
    check("a5_odata", 32'(o_data), 32'hA5);
    check("a5_latency", 32'(valid_cyc - fall), 32'd943);
    check("a5_ferr", 32'(nferr - f0), 32'd0);
    check("a5_busy_rise", 32'(busy_rise - fall), 32'd3);
    check("a5_busy_fall", 32'(busy_fall), 32'(valid_cyc));

    // 30-cycle glitch: false start
    n0 = nvalid; f0 = nferr;
    fall = cyc;
    drive(1'b0, 30);
    drive(1'b1, 100);
    check("gl_valid", 32'(nvalid - n0), 32'd0);
    check("gl_ferr", 32'(nferr - f0), 32'd0);
    check("gl_busy_rise", 32'(busy_rise - fall), 32'd3);
    check("gl_busy_len", 32'(busy_fall - busy_rise), 32'd49);
    check("gl_odata", 32'(o_data), 32'hA5);

    // 0x3C with stop held low for three bit times
    n0 = nvalid; f0 = nferr;
    send_frame(8'h3C, 1'b0, 3 * C);
    repeat (1100) @(negedge i_clk);
    check("fe_count", 32'(nferr - f0), 32'd1);
    check("fe_latency", 32'(ferr_cyc - fall), 32'd943);
    check("fe_valid", 32'(nvalid - n0), 32'd0);
    check("fe_odata", 32'(o_data), 32'hA5);
    check("fe_busy", 32'(o_busy), 32'h0);

    // back-to-back 0x00 / 0xFF, first stop bit shortened by 40
    n0 = nvalid;
    send_frame(8'h00, 1'b1, C - 40);
    send_frame(8'hFF, 1'b1, C);
    repeat (20) @(negedge i_clk);
    check("b2b_count", 32'(nvalid - n0), 32'd2);
    check("b2b_gap", 32'(valid_cyc - prev_valid_cyc), 32'd950);
    check("b2b_first", 32'(prev_data), 32'h00);
    check("b2b_second", 32'(last_data), 32'hFF);

    // lock lost during data bit 4
    n0 = nvalid; f0 = nferr;
    drive(1'b0, C);
    for (int i = 0; i < 4; i++) drive(i[0], C);
    drive(1'b1, 50);
    check("lk_busy_before", 32'(o_busy), 32'h1);
    i_locked = 1'b0;
    @(negedge i_clk);
    check("lk_busy_after", 32'(o_busy), 32'h0);
    drive(1'b1, 48);
    drive(1'b0, 3 * C);
    drive(1'b1, C + 20);
    check("lk_no_valid", 32'(nvalid - n0), 32'd0);
    check("lk_no_ferr", 32'(nferr - f0), 32'd0);
    check("lk_odata", 32'(o_data), 32'hFF);
    i_locked = 1'b1;
    repeat (10) @(negedge i_clk);
    send_frame(8'h81, 1'b1, C);
    repeat (20) @(negedge i_clk);
    check("lk_relock_count", 32'(nvalid - n0), 32'd1);
    check("lk_relock_data", 32'(o_data), 32'h81);

    // one-cycle reset mid-frame, remainder all ones
    n0 = nvalid; f0 = nferr;
    drive(1'b0, C);
    drive(1'b1, 150);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("mr_data", 32'(o_data), 32'h00);
    check("mr_busy", 32'(o_busy), 32'h0);
    check("mr_valid", 32'(o_valid), 32'h0);
    check("mr_ferr", 32'(o_frame_err), 32'h0);
    drive(1'b1, 1100);
    check("mr_no_valid", 32'(nvalid - n0), 32'd0);
    check("mr_no_ferr", 32'(nferr - f0), 32'd0);

    check("never_both", 32'(nboth), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/oifs_rx_uart.md
# oifs_rx_uart

Receive-side serial deserializer for the OIFS link. It runs on the 99 MHz PLL clock of the receiver board and oversamples the asynchronous optical line input. It recovers 8N1 frames (idle high, LSB first) and delivers each byte as a one-cycle strobe, along with a framing-error strobe. It is the counterpart of the transmit-side serializer.

## Interface

- CLKS_PER_BIT, default 99: clock cycles per bit. Default gives 1 Mbaud at 99 MHz. Legal range is 4..65535.
- i_clk, input, 1: system clock (PLL global output).
- i_rst, input, 1: synchronous, active-high reset.
- i_locked, input, 1: PLL lock. While low, the receiver is held in IDLE.
- i_rx, input, 1: raw asynchronous line input. Idle level is 1.
- o_data, output, 8: last correctly framed byte. Holds its value until the next good frame.
- o_valid, output, 1: one-cycle strobe; o_data is new in this cycle.
- o_frame_err, output, 1: one-cycle strobe when the stop bit is sampled as 0.
- o_busy, output, 1: high whenever state is not IDLE.

## Operation

- i_rx passes through a 2-flop synchronizer. Call the synchronized line s; s lags i_rx by 2 cycles. All logic uses s only.
- Bit counter: width $clog2(CLKS_PER_BIT). Half-bit value is CLKS_PER_BIT/2, rounded down.
- Bit index: 3 bits.
- FSM states and transitions:
  - IDLE: if i_locked=1 and s=0, load the counter with the half-bit value and go to START.
  - START: at half-bit expiry, sample s.
    - s=1: false start; return to IDLE with no strobe.
    - s=0: reload with CLKS_PER_BIT, set index to 0, go to DATA.
  - DATA: at each expiry, shift s into bit [index] of the shift register (LSB first). After index 7, reload and go to STOP.
  - STOP: at expiry, sample s.
    - s=1: o_data ← shift register, pulse o_valid, go to IDLE.
    - s=0: pulse o_frame_err, o_data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until s=1, then go to IDLE. This prevents a break condition from being taken as a new start.
- i_locked=0 in any state: go to IDLE on the next edge. Drop any partial frame, issue no strobe, leave o_data unchanged.
- Simultaneous events:
  - i_rst has priority over i_locked.
  - i_locked=0 has priority over a STOP-state strobe in the same cycle; that strobe is suppressed.
- The shift register is not observable and is not reset.

## Timing

- Reset values: state IDLE, o_data 8'h00, o_valid 0, o_frame_err 0, o_busy 0. The synchronizer flops reset to 1.
- Let T0 be the first cycle in IDLE with s=0 and i_locked=1. Sample k (0 = start, 1..8 = data, 9 = stop) is taken at T0 + CLKS_PER_BIT/2 + k·CLKS_PER_BIT.
- o_valid or o_frame_err is high for exactly one cycle, at T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1. The FSM is in IDLE in that same cycle.
- For default CLKS_PER_BIT=99, the strobe lands 941 cycles after T0. Adding the synchronizer gives 943 cycles from the i_rx falling edge.
- Back-to-back frames: a new start bit can be detected from the strobe cycle onward. This tolerates a stop bit cut short by up to CLKS_PER_BIT/2 − 1 cycles.
- o_busy goes high at T0+1 and low in the strobe cycle, or on the cycle after a false start or lock loss.
- o_valid and o_frame_err are never high in the same cycle.

## Structure

- Shared package oifs_pkg:
  - rx state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - OIFS_DATA_BITS = 8;
  - OIFS_IDLE_LEVEL = 1'b1.
- The transmit side already uses the same package constants.
- Sub-module oifs_sync2: a 2-flop synchronizer with reset value as a parameter. It is instantiated once here and is reusable for other async inputs.
- The FSM, counters and output registers all live in oifs_rx_uart.

## Test plan

- Reset, then lock, then the frame 0xA5 at CLKS_PER_BIT=99 → a single o_valid, 943 cycles after the i_rx falling edge, with o_data=8'hA5; o_frame_err stays 0; o_busy covers the frame.
- A low glitch of 30 cycles on an idle line → no strobe; o_busy high for about 49 cycles then 0; o_data unchanged.
- Frame 0x3C with stop bit held 0 for 3 bit times → one o_frame_err pulse; o_data keeps its previous value (0xA5); no new start until the line has been high for ≥1 cycle.
- Frames 0x00 then 0xFF with no idle gap, and the stop bit shortened by 40 cycles → two o_valid pulses, 990 − 40 cycles apart, with data 0x00 then 0xFF.
- i_locked dropped at data bit 4 → o_busy goes to 0 one cycle later; no strobe. After relock, frame 0x81 → o_valid with 0x81.
- i_rst asserted mid-frame for 1 cycle → all outputs at reset values; the remainder of the interrupted frame produces no strobe unless it contains a valid start-bit pattern.
